multi_line_buffer: RTL

//  Ring of NUM_LINES single-line pixel buffers feeding a KERNEL_ROWS-tall column window to the edge-detection kernel.

---
 rtl/lb_pkg.sv | 22 ++
 rtl/line_store.sv | 47 ++++
 rtl/multi_line_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the multi-line buffer: default geometry, pointer widths derived
// with clog2, and the modulo helper used to wrap line indices around the ring.
package lb_pkg;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned line_wrap(input int unsigned idx, input int unsigned num_lines);
        return idx % num_lines;
    endfunction

    localparam int unsigned LbDataWidth  = 8;
    localparam int unsigned LbImgWidth   = 512;
    localparam int unsigned LbNumLines   = 4;
    localparam int unsigned LbKernelRows = 3;

    localparam int unsigned LbColWidth  = ptr_width(LbImgWidth);
    localparam int unsigned LbLineWidth = ptr_width(LbNumLines);
    localparam int unsigned LbCntWidth  = $clog2(LbNumLines + 1);

endpackage

// File: rtl/line_store.sv
// One line of pixels: IMG_WIDTH x DATA_WIDTH RAM, one write port and one synchronous read
// port whose output register only updates on rd_en_i, so it holds a stalled window column.
module line_store
    import lb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LbDataWidth,
    parameter int unsigned IMG_WIDTH  = LbImgWidth,
    parameter int unsigned ADDR_WIDTH = ptr_width(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multi_line_buffer.sv
// Ring of NUM_LINES line stores emitting a KERNEL_ROWS-tall column per beat with valid/ready
// on both sides. Define LB_OVERFLOW_FLAG_EN to add a sticky overflow output.
module multi_line_buffer
    import lb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = LbDataWidth,
    parameter int unsigned IMG_WIDTH   = LbImgWidth,
    parameter int unsigned NUM_LINES   = LbNumLines,
    parameter int unsigned KERNEL_ROWS = LbKernelRows
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               inPixel,
    input  logic                                inPixelValid,
    output logic                                inPixelReady,
    input  logic                                outPixelReady,
    output logic                                outWindowValid,
    output logic [KERNEL_ROWS*DATA_WIDTH-1:0]   outWindow,
    output logic                                outLineDone,
    output logic [$clog2(NUM_LINES+1)-1:0]      linesFilled
`ifdef LB_OVERFLOW_FLAG_EN
    ,
    output logic                                overflow
`endif
);

    localparam int unsigned ColW  = ptr_width(IMG_WIDTH);
    localparam int unsigned LineW = ptr_width(NUM_LINES);
    localparam int unsigned CntW  = $clog2(NUM_LINES + 1);

    localparam logic [ColW-1:0] LastCol  = ColW'(IMG_WIDTH - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(NUM_LINES);
    localparam logic [CntW-1:0] AvailCnt = CntW'(KERNEL_ROWS);

    // A spare line is what lets the writer fill while a full window is being drained.
    if (NUM_LINES < KERNEL_ROWS + 1) begin : g_bad_cfg
        $error("multi_line_buffer: NUM_LINES must be at least KERNEL_ROWS+1");
    end

    logic [ColW-1:0]  wr_col_d, wr_col_q;
    logic [ColW-1:0]  rd_col_d, rd_col_q;
    logic [LineW-1:0] rd_line_d, rd_line_q;
    logic [LineW-1:0] win_base_d, win_base_q;
    logic [CntW-1:0]  filled_d, filled_q;
    logic             valid_d, valid_q;
    logic             line_done_d, line_done_q;

    logic             in_ready, wr_fire, wr_last;
    logic             avail, load, rd_last;
    logic [LineW-1:0] wr_line;

    logic [DATA_WIDTH-1:0] line_data [NUM_LINES];

    always_comb begin
        wr_line  = LineW'(line_wrap(32'(rd_line_q) + 32'(filled_q), NUM_LINES));
        in_ready = filled_q < FullCnt;
        wr_fire  = inPixelValid && in_ready;
        wr_last  = wr_fire && (wr_col_q == LastCol);
        avail    = filled_q >= AvailCnt;
        load     = avail && (!valid_q || outPixelReady);
        rd_last  = load && (rd_col_q == LastCol);

        wr_col_d = wr_col_q;
        if (wr_fire) begin
            wr_col_d = wr_last ? '0 : wr_col_q + ColW'(1);
        end

        rd_col_d   = rd_col_q;
        rd_line_d  = rd_line_q;
        win_base_d = win_base_q;
        if (load) begin
            rd_col_d   = rd_last ? '0 : rd_col_q + ColW'(1);
            win_base_d = rd_line_q;
        end
        if (rd_last) begin
            rd_line_d = LineW'(line_wrap(32'(rd_line_q) + 32'd1, NUM_LINES));
        end

        // A line completing and a line freeing on the same edge cancel out.
        filled_d = filled_q;
        if (wr_last && !rd_last) begin
            filled_d = filled_q + CntW'(1);
        end else if (!wr_last && rd_last) begin
            filled_d = filled_q - CntW'(1);
        end

        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (outPixelReady) begin
            valid_d = 1'b0;
        end

        line_done_d = rd_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_col_q    <= '0;
            rd_col_q    <= '0;
            rd_line_q   <= '0;
            win_base_q  <= '0;
            filled_q    <= '0;
            valid_q     <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            wr_col_q    <= wr_col_d;
            rd_col_q    <= rd_col_d;
            rd_line_q   <= rd_line_d;
            win_base_q  <= win_base_d;
            filled_q    <= filled_d;
            valid_q     <= valid_d;
            line_done_q <= line_done_d;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        line_store #(
            .DATA_WIDTH (DATA_WIDTH),
            .IMG_WIDTH  (IMG_WIDTH),
            .ADDR_WIDTH (ColW)
        ) u_line_store (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_fire && (wr_line == LineW'(i))),
            .wr_addr_i (wr_col_q),
            .wr_data_i (inPixel),
            .rd_en_i   (load),
            .rd_addr_i (rd_col_q),
            .rd_data_o (line_data[i])
        );
    end

    // Every store reads on a load; the captured base line picks which ones form the column.
    always_comb begin
        outWindow = '0;
        for (int unsigned k = 0; k < KERNEL_ROWS; k++) begin
            outWindow[k*DATA_WIDTH +: DATA_WIDTH] =
                line_data[LineW'(line_wrap(32'(win_base_q) + k, NUM_LINES))];
        end
    end

    assign inPixelReady   = in_ready;
    assign outWindowValid = valid_q;
    assign outLineDone    = line_done_q;
    assign linesFilled    = filled_q;

`ifdef LB_OVERFLOW_FLAG_EN
    logic overflow_d, overflow_q;

    always_comb begin
        overflow_d = overflow_q || (inPixelValid && !in_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule
